// File: rtl/alu_mc_pkg.sv
// Shared types and helpers for the multi-cycle ALU (alu_mc).
// Optional early-terminating multiply is enabled by defining ALU_MC_EARLY_TERM_EN.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN: flags only, no register writeback.
  function automatic logic is_compare(alu_op_e op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/alu_mc_core.sv
// Combinational evaluator for the 16 data-processing ops; produces result and NZCV.
// Carry-in and old V come from the committed flag register in the parent.
module alu_mc_core
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  input  logic             carry_in,
  input  logic             shift_c,
  input  logic             v_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv
);

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_cin;
  logic             w_arith;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    w_op_a  = a;
    w_op_b  = b;
    w_cin   = 1'b0;
    w_arith = 1'b1;
    case (op)
      OP_SUB, OP_CMP: begin w_op_b = ~b; w_cin = 1'b1; end
      OP_RSB:         begin w_op_a = b; w_op_b = ~a; w_cin = 1'b1; end
      OP_ADD, OP_CMN: w_cin = 1'b0;
      OP_ADC:         w_cin = carry_in;
      OP_SBC:         begin w_op_b = ~b; w_cin = carry_in; end
      OP_RSC:         begin w_op_a = b; w_op_b = ~a; w_cin = carry_in; end
      default:        w_arith = 1'b0;
    endcase
  end

  always_comb begin
    w_logic = '0;
    case (op)
      OP_AND, OP_TST: w_logic = a & b;
      OP_EOR, OP_TEQ: w_logic = a ^ b;
      OP_ORR:         w_logic = a | b;
      OP_MOV:         w_logic = b;
      OP_BIC:         w_logic = a & ~b;
      OP_MVN:         w_logic = ~b;
      default:        w_logic = '0;
    endcase
  end

  assign w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b} + {{WIDTH{1'b0}}, w_cin};
  assign result = w_arith ? w_sum[WIDTH-1:0] : w_logic;

  always_comb begin
    nzcv         = '0;
    nzcv[FLAG_N] = result[WIDTH-1];
    nzcv[FLAG_Z] = (result == '0);
    nzcv[FLAG_C] = w_arith ? w_sum[WIDTH] : shift_c;
    nzcv[FLAG_V] = w_arith ? ((w_op_a[WIDTH-1] == w_op_b[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != w_op_a[WIDTH-1]))
                           : v_in;
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: one-cycle data-processing ops, shift-add MUL/MLA, NZCV register,
// valid/ready on both sides. Define ALU_MC_EARLY_TERM_EN to stop MUL once the multiplier empties.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_CYC = WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic             is_mul,
  input  logic             mla,
  input  logic             set_flags,
  input  logic             shift_c,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] SrcC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             wr_en,
  output logic [3:0]       ALUFlags
);

  localparam int CNT_W = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_wr_en;
  logic [3:0]       r_flags;
  logic [3:0]       r_pend_flags;
  logic             r_commit;

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_core_res;
  logic [3:0]       w_core_nzcv;
  logic [WIDTH-1:0] w_acc_init;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_mplier_next;
  logic             w_mul_last;

  assign w_op = alu_op_e'(alu_op);

  alu_mc_core #(.WIDTH(WIDTH)) u_core (
    .a        (SrcA),
    .b        (SrcB),
    .op       (w_op),
    .carry_in (r_flags[FLAG_C]),
    .shift_c  (shift_c),
    .v_in     (r_flags[FLAG_V]),
    .result   (w_core_res),
    .nzcv     (w_core_nzcv)
  );

  assign w_acc_init    = mla ? SrcC : '0;
  assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_next = r_mplier >> 1;

`ifdef ALU_MC_EARLY_TERM_EN
  assign w_mul_last = (r_cnt == CNT_W'(MUL_CYC - 1)) || (w_mplier_next == '0);
`else
  assign w_mul_last = (r_cnt == CNT_W'(MUL_CYC - 1));
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign ALUResult = r_result;
  assign wr_en     = r_wr_en;
  assign ALUFlags  = r_flags;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_cnt        <= '0;
      r_result     <= '0;
      r_wr_en      <= 1'b0;
      r_flags      <= '0;
      r_pend_flags <= '0;
      r_commit     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && !is_mul) begin
            r_result     <= w_core_res;
            r_pend_flags <= w_core_nzcv;
            r_wr_en      <= !is_compare(w_op);
            r_commit     <= set_flags || is_compare(w_op);
            r_state      <= DONE;
          end else if (in_valid) begin
            r_acc    <= w_acc_init;
            r_mcand  <= SrcA;
            r_mplier <= SrcB;
            r_cnt    <= '0;
            r_wr_en  <= 1'b1;
            r_commit <= set_flags;
            r_state  <= MUL;
`ifdef ALU_MC_EARLY_TERM_EN
            // Zero multiplier: the product is just the accumulate term.
            if (SrcB == '0) begin
              r_result     <= w_acc_init;
              r_pend_flags <= {w_acc_init[WIDTH-1], (w_acc_init == '0),
                               r_flags[FLAG_C], r_flags[FLAG_V]};
              r_state      <= DONE;
            end
`endif
          end
        end
        MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_mul_last) begin
            r_result     <= w_acc_next;
            r_pend_flags <= {w_acc_next[WIDTH-1], (w_acc_next == '0),
                             r_flags[FLAG_C], r_flags[FLAG_V]};
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (r_commit) r_flags <= r_pend_flags;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
